// File: rtl/axi4_pchase_rd_responder.sv
// AXI4 read-channel responder that returns synthetic pointer-chase data.
// Each beat carries the address of the beat plus the next pointer in the chain,
// so a chasing initiator can walk a deterministic linked list without memory.
//
// Handshake: AR and R follow strict AXI valid/ready semantics. A transfer happens
// on a rising edge where valid and ready are both high. Once rvalid is raised it
// stays high, with rdata/rid/rresp/rlast held stable, until rready accepts the beat.
module axi4_pchase_rd_responder #(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 512,
  parameter int          ID_W        = 1,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RD_LAT      = 8,
  parameter logic [63:0] STRIDE      = 64'h1000,
  parameter int          REGION_BITS = 20,
  parameter logic [63:0] BASE        = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_axi_arvalid,
  output logic              io_axi_arready,
  input  logic [ADDR_W-1:0] io_axi_araddr,
  input  logic [ID_W-1:0]   io_axi_arid,
  input  logic [7:0]        io_axi_arlen,
  input  logic [2:0]        io_axi_arsize,
  input  logic [1:0]        io_axi_arburst,
  output logic              io_axi_rvalid,
  input  logic              io_axi_rready,
  output logic [DATA_W-1:0] io_axi_rdata,
  output logic [ID_W-1:0]   io_axi_rid,
  output logic [1:0]        io_axi_rresp,
  output logic              io_axi_rlast,
  output logic [31:0]       io_cnt_ar,
  output logic [31:0]       io_cnt_beat,
  output logic [31:0]       io_cnt_err
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam int          ENT_W       = ADDR_W + ID_W + 8 + 3 + 2;
  localparam logic [63:0] REGION_MASK = (64'd1 << REGION_BITS) - 64'd1;

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                arready_q, arready_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [ID_W-1:0]     w_id_q, w_id_d;
  logic [7:0]          w_len_q, w_len_d;
  logic [2:0]          w_size_q, w_size_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic                w_err_q, w_err_d;
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          lat_q, lat_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic [31:0]         cnt_ar_q, cnt_ar_d, cnt_beat_q, cnt_beat_d, cnt_err_q, cnt_err_d;

  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic                push, pop, take_head, fifo_empty;
  logic [PTR_W:0]      occ_d;
  logic [ADDR_W-1:0]   h_addr;
  logic [ID_W-1:0]     h_id;
  logic [7:0]          h_len;
  logic [2:0]          h_size;
  logic [1:0]          h_burst;
  logic                h_err;

  logic [7:0]          beat_n;
  logic [ADDR_W-1:0]   off, incr_a, wmask, beat_a;
  logic [63:0]         a64, nxt;
  logic [DATA_W-1:0]   beat_data;

  assign push       = io_axi_arvalid & arready_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign {h_addr, h_id, h_len, h_size, h_burst} = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // Classify the burst at the FIFO head: reserved burst type, oversize beat, or illegal wrap length.
  always_comb begin
    h_err = 1'b0;
    if (h_burst == 2'b11) h_err = 1'b1;
    if ((32'd1 << h_size) > 32'(DATA_W / 8)) h_err = 1'b1;
    if (h_burst == 2'b10 && !(h_len inside {8'd1, 8'd3, 8'd7, 8'd15})) h_err = 1'b1;
  end

  // AR storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {io_axi_araddr, io_axi_arid, io_axi_arlen,
                                                io_axi_arsize, io_axi_arburst};
  end

  // Address and payload of the beat about to be presented (first beat, or the one after the current).
  always_comb begin
    beat_n = rvalid_q ? beat_q + 8'd1 : beat_q;
    off    = ADDR_W'(beat_n) << w_size_q;
    incr_a = w_addr_q + off;
    wmask  = ((ADDR_W'(w_len_q) + ADDR_W'(1)) << w_size_q) - ADDR_W'(1);
    case (w_burst_q)
      2'b01:   beat_a = incr_a;
      2'b10:   beat_a = (w_addr_q & ~wmask) | (incr_a & wmask);
      default: beat_a = w_addr_q;
    endcase
    a64 = 64'(beat_a);
    nxt = BASE + ((a64 - BASE + STRIDE) & REGION_MASK);
    beat_data = '0;
    if (!w_err_q) begin
      beat_data[63:0]   = nxt;
      beat_data[127:64] = a64;
    end
  end

  // Burst sequencer: next state, working registers, registered R outputs and counters.
  always_comb begin
    state_d    = state_q;
    w_addr_d   = w_addr_q;
    w_id_d     = w_id_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_burst_d  = w_burst_q;
    w_err_d    = w_err_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    cnt_ar_d   = push ? cnt_ar_q + 32'd1 : cnt_ar_q;
    cnt_beat_d = cnt_beat_q;
    cnt_err_d  = cnt_err_q;
    take_head  = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: take_head = !fifo_empty;
      S_LAT: begin
        lat_d = lat_q - 8'd1;
        if (lat_q <= 8'd1) state_d = S_DATA;
      end
      S_DATA: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = beat_data;
          rid_d    = w_id_q;
          rresp_d  = w_err_q ? 2'b10 : 2'b00;
          rlast_d  = (beat_n == w_len_q);
        end else if (io_axi_rready) begin
          cnt_beat_d = cnt_beat_q + 32'd1;
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rdata_d   = '0;
            rid_d     = '0;
            rresp_d   = 2'b00;
            rlast_d   = 1'b0;
            state_d   = S_IDLE;
            take_head = !fifo_empty;
          end else begin
            beat_d  = beat_n;
            rdata_d = beat_data;
            rresp_d = w_err_q ? 2'b10 : 2'b00;
            rlast_d = (beat_n == w_len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load the next burst from the FIFO head; shared by IDLE and end-of-burst.
    if (take_head) begin
      pop       = 1'b1;
      w_addr_d  = h_addr;
      w_id_d    = h_id;
      w_len_d   = h_len;
      w_size_d  = h_size;
      w_burst_d = h_burst;
      w_err_d   = h_err;
      beat_d    = 8'd0;
      if (h_err) cnt_err_d = cnt_err_q + 32'd1;
      if (RD_LAT == 0) begin
        state_d = S_DATA;
      end else begin
        state_d = S_LAT;
        lat_d   = 8'(RD_LAT);
      end
    end
  end

  // FIFO pointers and registered arready (low whenever the FIFO will be full).
  always_comb begin
    wr_ptr_d  = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d  = rd_ptr_q + (PTR_W + 1)'(pop);
    occ_d     = wr_ptr_d - rd_ptr_d;
    arready_d = (occ_d != (PTR_W + 1)'(FIFO_DEPTH));
  end

  // State register; reset abandons any burst in flight and flushes the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      arready_q  <= 1'b0;
      w_addr_q   <= '0;
      w_id_q     <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_err_q    <= 1'b0;
      beat_q     <= '0;
      lat_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      cnt_ar_q   <= '0;
      cnt_beat_q <= '0;
      cnt_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      arready_q  <= arready_d;
      w_addr_q   <= w_addr_d;
      w_id_q     <= w_id_d;
      w_len_q    <= w_len_d;
      w_size_q   <= w_size_d;
      w_burst_q  <= w_burst_d;
      w_err_q    <= w_err_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      cnt_ar_q   <= cnt_ar_d;
      cnt_beat_q <= cnt_beat_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign io_axi_arready = arready_q;
  assign io_axi_rvalid  = rvalid_q;
  assign io_axi_rdata   = rdata_q;
  assign io_axi_rid     = rid_q;
  assign io_axi_rresp   = rresp_q;
  assign io_axi_rlast   = rlast_q;
  assign io_cnt_ar      = cnt_ar_q;
  assign io_cnt_beat    = cnt_beat_q;
  assign io_cnt_err     = cnt_err_q;

endmodule
